// File: rtl/sar_search_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_pkg
//  Description : Shared types and helpers for the successive-approximation
//                search engine. Holds the engine state encoding and the
//                trial-word update used on every SEARCH cycle.
//  Revision    : 1.0  initial release
// ============================================================================
package sar_search_pkg;

    // Widest search the trial helper supports; the engine slices down to
    // its own WIDTH.
    localparam int SAR_MAX_W = 32;
    localparam int SAR_POS_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } sar_state_t;

    // Next trial word: resolve the bit under test (clear it when the hidden
    // value is below the trial), then raise the next lower bit as the new
    // guess. At position 0 there is no lower bit, so only the resolve step
    // applies and the result is the final answer.
    function automatic logic [SAR_MAX_W-1:0] sar_next_trial(
        input logic [SAR_MAX_W-1:0] trial,
        input logic [SAR_POS_W-1:0] pos,
        input logic                 clr
    );
        logic [SAR_MAX_W-1:0] nxt;
        nxt = trial;
        if (clr) begin
            nxt[pos] = 1'b0;
        end
        if (pos != '0) begin
            nxt[pos - SAR_POS_W'(1)] = 1'b1;
        end
        return nxt;
    endfunction

endpackage : sar_search_pkg
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search
//  Description : Successive-approximation search engine. Drives the trial
//                reference rfr MSB-first into an external magnitude
//                comparator, consumes its grt/lst verdicts and converges on
//                the comparator's hidden val.
//
//  Ports       : clk      - clock
//                rst_n    - synchronous active-low reset
//                str_vld  - start request        str_rdy - engine idle
//                rfr      - trial reference to the comparator
//                grt/lst  - comparator verdicts (val > rfr / val < rfr)
//                res_vld  - result valid         res_rdy - result accepted
//                res      - search result
//                err      - grt and lst seen high together this search
//
//  Options     : SAR_SEARCH_EARLY_EXIT_EN - when defined, an equal verdict
//                (grt=0, lst=0) finishes the search at once with the current
//                trial as the result.
//
//  Revision    : 1.0  initial release
// ============================================================================
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             str_vld,
    output logic             str_rdy,
    output logic [WIDTH-1:0] rfr,
    input  logic             grt,
    input  logic             lst,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [WIDTH-1:0] res,
    output logic             err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] c_FIRST_TRIAL = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_W-1:0] c_TOP_POS     = CNT_W'(WIDTH - 1);

    sar_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_rfr;
    logic [WIDTH-1:0]  r_res;
    logic              r_res_vld;
    logic              r_str_rdy;
    logic              r_err;

    logic [SAR_MAX_W-1:0] w_next_full;
    logic [WIDTH-1:0]     w_next;
    logic                 w_unused;

    // A simultaneous grt/lst is resolved as "below", so lst alone decides.
    assign w_next_full = sar_next_trial(SAR_MAX_W'(r_rfr), SAR_POS_W'(r_cnt), lst);
    assign w_next      = w_next_full[WIDTH-1:0];
    assign w_unused    = &{1'b0, w_next_full};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rfr     <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_str_rdy <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (str_vld) begin
                        r_rfr     <= c_FIRST_TRIAL;
                        r_cnt     <= c_TOP_POS;
                        r_err     <= 1'b0;
                        r_str_rdy <= 1'b0;
                        r_state   <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (grt && lst) begin
                        r_err <= 1'b1;
                    end
`ifdef SAR_SEARCH_EARLY_EXIT_EN
                    if (!grt && !lst) begin
                        r_res     <= r_rfr;
                        r_res_vld <= 1'b1;
                        r_state   <= DONE;
                    end else
`endif
                    if (r_cnt == '0) begin
                        // rfr is left on the last trial; only res carries
                        // the resolved LSB.
                        r_res     <= w_next;
                        r_res_vld <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_rfr <= w_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    if (res_rdy) begin
                        r_res_vld <= 1'b0;
                        r_str_rdy <= 1'b1;
                        r_state   <= IDLE;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_res_vld <= 1'b0;
                    r_str_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign str_rdy = r_str_rdy;
    assign rfr     = r_rfr;
    assign res     = r_res;
    assign res_vld = r_res_vld;
    assign err     = r_err;

endmodule : sar_search
`default_nettype wire
